// File: rtl/nvram_upload.sv
// HPS read-back responder for the NVRAM/hiscore RAM on the ioctl bus.
// It serves ioctl_rd requests with wait flow control and raises save requests when the RAM is dirty.
module nvram_upload #(
  parameter int unsigned AW        = 10,
  parameter logic [7:0]  IDX       = 8'd4,
  parameter int unsigned RD_LAT    = 1,
  parameter logic [23:0] DIRTY_DLY = 24'd6000000
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic          ioctl_upload_req,
  input  logic          save_trigger,
  input  logic          game_wr,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rd,
  input  logic [7:0]    ram_q
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LAT   = 2'd1;
  localparam logic [1:0] S_PAD   = 2'd2;
  localparam logic [1:0] LAT_END = 2'(RD_LAT);

  logic [1:0]  state;
  logic [1:0]  lat_cnt;
  logic [23:0] timer;
  logic        dirty, wr_in_upl, sel_q, st_q;
  logic        sel, rd_go, in_range, upl_end, dirty_keep, auto_req, st_rise;

  assign sel      = ioctl_upload & (ioctl_index == IDX);
  assign rd_go    = (state == S_IDLE) & ioctl_rd & sel;
  assign in_range = (ioctl_addr[24:AW] == '0);

  // Read side; any non-idle state aborts when the upload drops, keeping the last din.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      lat_cnt    <= '0;
      ioctl_din  <= 8'hFF;
      ioctl_wait <= 1'b0;
      ram_addr   <= '0;
      ram_rd     <= 1'b0;
    end else begin
      ram_rd <= 1'b0;
      case (state)
        S_IDLE: if (rd_go) begin
          ioctl_wait <= 1'b1;
          if (in_range) begin
            ram_addr <= ioctl_addr[AW-1:0];
            ram_rd   <= 1'b1;
            lat_cnt  <= '0;
            state    <= S_LAT;
          end else begin
            state <= S_PAD;
          end
        end
        S_LAT: begin
          if (!ioctl_upload) begin
            state      <= S_IDLE;
            ioctl_wait <= 1'b0;
          end else if (lat_cnt == LAT_END) begin
            ioctl_din  <= ram_q;
            ioctl_wait <= 1'b0;
            state      <= S_IDLE;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        S_PAD: begin
          state      <= S_IDLE;
          ioctl_wait <= 1'b0;
          if (ioctl_upload) ioctl_din <= 8'hFF;
        end
        default: begin
          state      <= S_IDLE;
          ioctl_wait <= 1'b0;
        end
      endcase
    end
  end

  // An upload that saw no game write has just saved everything, so dirty is dropped.
  assign upl_end    = sel_q & ~ioctl_upload;
  assign dirty_keep = dirty & ~(upl_end & ~wr_in_upl);
  assign auto_req   = (DIRTY_DLY != 24'd0) & dirty_keep & (timer == 24'd0) & ~game_wr & ~ioctl_upload;
  assign st_rise    = save_trigger & ~st_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ioctl_upload_req <= 1'b0;
      dirty            <= 1'b0;
      timer            <= '0;
      wr_in_upl        <= 1'b0;
      sel_q            <= 1'b0;
      st_q             <= 1'b0;
    end else begin
      sel_q            <= sel;
      st_q             <= save_trigger;
      ioctl_upload_req <= (st_rise & ~ioctl_upload) | auto_req;
      if (game_wr) begin
        dirty <= 1'b1;
        timer <= DIRTY_DLY;
      end else begin
        dirty <= dirty_keep & ~auto_req;
        if (timer != 24'd0) timer <= timer - 24'd1;
      end
      if (upl_end)              wr_in_upl <= 1'b0;
      else if (game_wr && sel)  wr_in_upl <= 1'b1;
    end
  end
endmodule

// File: tb/tb_nvram_upload.sv
// Randomized bench for nvram_upload with an event-level reference model and directed literal checks.
module tb_nvram_upload;
  localparam int AW = 10;
  localparam int RD_LAT = 3;
  localparam logic [7:0] IDX = 8'd4;
  localparam int DLY = 100;

  logic clk_sys = 1'b0;
  logic reset = 1'b0;
  logic ioctl_upload = 1'b0, ioctl_rd = 1'b0, save_trigger = 1'b0, game_wr = 1'b0;
  logic [7:0] ioctl_index = 8'd0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0] ioctl_din, ram_q;
  logic ioctl_wait, ioctl_upload_req, ram_rd;
  logic [AW-1:0] ram_addr;

  nvram_upload #(.AW(AW), .IDX(IDX), .RD_LAT(RD_LAT), .DIRTY_DLY(24'd100)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
    .ioctl_upload_req(ioctl_upload_req), .save_trigger(save_trigger), .game_wr(game_wr),
    .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_q(ram_q));

  always #5 clk_sys = ~clk_sys;

  int tests = 0, fails = 0, cyc = 0;
  int rd_pulses = 0, req_cnt = 0, req_last = -1;
  bit chk_en = 0;

  // RAM contents are addr[7:0]^5A, returned RD_LAT cycles after the address is presented
  logic [7:0] qp [RD_LAT];
  always @(posedge clk_sys) begin
    qp[0] <= ram_addr[7:0] ^ 8'h5A;
    for (int i = 1; i < RD_LAT; i++) qp[i] <= qp[i-1];
  end
  assign ram_q = qp[RD_LAT-1];

  always @(posedge clk_sys) cyc++;
  always @(negedge clk_sys) begin
    if (ram_rd) rd_pulses++;
    if (ioctl_upload_req) begin req_cnt++; req_last = cyc; end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a read is a countdown of remaining wait cycles; dirty age is edges since the last write
  int m_left = 0, m_since = 100000;
  logic [7:0] m_din = 8'hFF, m_pend = 8'hFF;
  logic m_rd = 0, m_req = 0, m_dirty = 0, m_wru = 0, m_stp = 0, m_selp = 0;
  logic [AW-1:0] m_addr = '0;
  logic m_sel, m_end, m_rise, m_keep, m_auto;

  always @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      m_left = 0; m_din = 8'hFF; m_rd = 0; m_addr = '0; m_req = 0;
      m_dirty = 0; m_since = 100000; m_wru = 0; m_stp = 0; m_selp = 0;
    end else begin
      m_sel = ioctl_upload && (ioctl_index == IDX);
      m_rd = 0;
      if (m_left > 0) begin
        if (!ioctl_upload) m_left = 0;
        else begin
          m_left--;
          if (m_left == 0) m_din = m_pend;
        end
      end else if (ioctl_rd && m_sel) begin
        if (ioctl_addr >= (25'd1 << AW)) begin
          m_left = 1; m_pend = 8'hFF;
        end else begin
          m_left = RD_LAT + 1; m_pend = ioctl_addr[7:0] ^ 8'h5A;
          m_rd = 1; m_addr = ioctl_addr[AW-1:0];
        end
      end
      m_end  = m_selp && !ioctl_upload;
      m_rise = save_trigger && !m_stp;
      m_keep = m_dirty && !(m_end && !m_wru);
      m_auto = m_keep && (m_since >= DLY) && !game_wr && !ioctl_upload;
      m_req  = (m_rise && !ioctl_upload) || m_auto;
      if (game_wr) begin m_dirty = 1; m_since = 0; end
      else begin
        m_dirty = m_keep && !m_auto;
        if (m_since < 100000) m_since++;
      end
      if (m_end) m_wru = 0;
      else if (game_wr && m_sel) m_wru = 1;
      m_selp = m_sel; m_stp = save_trigger;
    end
  end

  always @(negedge clk_sys) if (chk_en) begin
    chk("wait", ioctl_wait, m_left > 0);
    chk("ram_rd", ram_rd, m_rd);
    chk("ram_addr", ram_addr, m_addr);
    chk("upload_req", ioctl_upload_req, m_req);
    if (m_left == 0) chk("din", ioctl_din, m_din);
  end

  task automatic tick();
    @(posedge clk_sys); #2;
  endtask

  task automatic rd_txn(input logic [24:0] a, input logic [7:0] idx, output int wcnt, output int rcnt);
    int r0;
    r0 = rd_pulses;
    ioctl_index = idx; ioctl_addr = a; ioctl_rd = 1;
    tick();
    ioctl_rd = 0;
    wcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_sys);
      if (ioctl_wait) wcnt++; else break;
    end
    #1 rcnt = rd_pulses - r0;
  endtask

  int w, r, t0, r0;

  initial begin
    #1 reset = 1;
    #1 chk_en = 1;
    tick(); tick();
    chk("rst_din", ioctl_din, 8'hFF);
    chk("rst_wait", ioctl_wait, 0);
    chk("rst_req", ioctl_upload_req, 0);
    chk("rst_ram_rd", ram_rd, 0);
    chk("rst_ram_addr", ram_addr, 0);
    reset = 0;
    tick();

    // in-range read, unselected read, out-of-range pad
    ioctl_upload = 1; ioctl_index = IDX; tick();
    rd_txn(25'h005, IDX, w, r);
    chk("rd5_wait_cycles", w, RD_LAT + 1); chk("rd5_ram_rd", r, 1);
    chk("rd5_din", ioctl_din, 8'h5F); chk("rd5_addr", ram_addr, 5);
    tick();
    rd_txn(25'h010, 8'd3, w, r);
    chk("idx3_wait_cycles", w, 0); chk("idx3_ram_rd", r, 0); chk("idx3_din", ioctl_din, 8'h5F);
    tick();
    rd_txn(25'h400, IDX, w, r);
    chk("oor_wait_cycles", w, 1); chk("oor_ram_rd", r, 0); chk("oor_din", ioctl_din, 8'hFF);
    tick();
    ioctl_upload = 0; repeat (3) tick();

    // auto-save after quiet period
    r0 = req_cnt;
    game_wr = 1; tick(); t0 = cyc; game_wr = 0;
    repeat (300) tick();
    chk("auto_req_count", req_cnt - r0, 1); chk("auto_req_cycle", req_last, t0 + 101);

    // writes during an upload defer the request until after the upload
    r0 = req_cnt;
    ioctl_upload = 1; ioctl_index = IDX; tick();
    game_wr = 1; tick(); game_wr = 0;
    repeat (9) tick();
    game_wr = 1; tick(); t0 = cyc; game_wr = 0;
    repeat (30) tick();
    ioctl_upload = 0;
    repeat (150) tick();
    chk("upl_req_count", req_cnt - r0, 1); chk("upl_req_cycle", req_last, t0 + 101);

    // OSD save: one pulse per rising edge
    r0 = req_cnt;
    save_trigger = 1; tick(); t0 = cyc;
    repeat (50) tick();
    chk("osd_req_count", req_cnt - r0, 1); chk("osd_req_cycle", req_last, t0);
    save_trigger = 0; tick();

    // reset in the middle of a RAM read
    ioctl_upload = 1; ioctl_index = IDX; ioctl_addr = 25'h007; ioctl_rd = 1; tick();
    ioctl_rd = 0; tick();
    chk("midlat_wait_before", ioctl_wait, 1);
    reset = 1; #1;
    chk("midlat_wait", ioctl_wait, 0); chk("midlat_req", ioctl_upload_req, 0);
    chk("midlat_din", ioctl_din, 8'hFF); chk("midlat_ram_rd", ram_rd, 0);
    tick(); reset = 0; tick();
    rd_txn(25'h009, IDX, w, r);
    chk("post_rst_wait_cycles", w, RD_LAT + 1); chk("post_rst_din", ioctl_din, 8'h53);
    tick();

    // randomized traffic against the model
    for (int i = 0; i < 5000; i++) begin
      ioctl_rd = ($urandom % 3) == 0;
      ioctl_addr = ($urandom % 4 == 0) ? 25'($urandom) : 25'($urandom % 1024);
      ioctl_index = ($urandom % 8 == 0) ? 8'd3 : IDX;
      if ($urandom % 80 == 0) ioctl_upload = ~ioctl_upload;
      if ($urandom % 40 == 0) save_trigger = ~save_trigger;
      game_wr = ($urandom % 200) == 0;
      tick();
    end
    ioctl_rd = 0; game_wr = 0;
    repeat (5) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
